// File: rtl/wb_pkg.sv
// Write-back stage package: source-select encodings and default widths
// shared by etapa_wb and its scoreboard.
package wb_pkg;

    localparam int WB_DATA_W = 32;  // data / RAM word width
    localparam int WB_IMM_W  = 8;   // immediate width
    localparam int WB_REG_AW = 3;   // register address width
    localparam int WB_CNT_W  = 2;   // scoreboard pending counter width
    localparam int WB_ELEM_W = 8;   // vector element index width

    typedef enum logic [1:0] {
        WB_SEL_DATA = 2'b00,
        WB_SEL_MEM  = 2'b01,
        WB_SEL_IMM  = 2'b10,
        WB_SEL_NONE = 2'b11
    } wb_sel_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register pending-write scoreboard.
//   clk, rst            : clock, async active-high reset
//   issue_valid/dest    : decode issues a register-writing instruction
//   commit/commit_dest  : write-back commits a register write this edge
//   chk_a, chk_b        : decode source registers to check
//   issue_ready         : issue_dest counter not saturated
//   hazard_a, hazard_b  : checked register has a pending write
//   busy_mask           : bit i set when register i counter is nonzero
module wb_scoreboard
    import wb_pkg::*;
#(
    parameter int REG_AW = WB_REG_AW,
    parameter int CNT_W  = WB_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_valid,
    input  logic [REG_AW-1:0]      issue_dest,
    input  logic                   commit,
    input  logic [REG_AW-1:0]      commit_dest,
    input  logic [REG_AW-1:0]      chk_a,
    input  logic [REG_AW-1:0]      chk_b,
    output logic                   issue_ready,
    output logic                   hazard_a,
    output logic                   hazard_b,
    output logic [(1<<REG_AW)-1:0] busy_mask
);

    localparam int NUM_REGS = 1 << REG_AW;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
    logic                           inc_ok;

    assign issue_ready = (cnt[issue_dest] != CNT_MAX);
    assign inc_ok      = issue_valid && issue_ready;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        logic             inc_g, dec_g;
        logic [CNT_W-1:0] cnt_q;

        assign inc_g = inc_ok && (issue_dest == REG_AW'(g));
        assign dec_g = commit && (commit_dest == REG_AW'(g));

        // Issue and commit on the same register cancel out; a commit on an
        // idle register is clamped at zero.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                cnt_q <= '0;
            else if (inc_g && !dec_g)
                cnt_q <= cnt_q + CNT_W'(1);
            else if (dec_g && !inc_g && cnt_q != '0)
                cnt_q <= cnt_q - CNT_W'(1);
        end

        assign cnt[g]       = cnt_q;
        assign busy_mask[g] = |cnt_q;
    end

    // No same-cycle bypass: decode re-checks on the following cycle.
    assign hazard_a = busy_mask[chk_a];
    assign hazard_b = busy_mask[chk_b];

endmodule

// File: rtl/etapa_wb.sv
// Write-back stage. Captures MEM-stage outputs (E1), commits the selected
// source to the register file one edge later (E2) so RAM read data lines up.
//   clk, rst                      : clock, async active-high reset
//   valid_in, data_in,
//   inmediate_in, dir_dest_in,
//   sel_wb, last_in               : MEM-stage instruction
//   mem_q                         : RAM read data, one cycle after valid_in
//   issue_valid, issue_dest       : decode issue into the scoreboard
//   chk_a, chk_b                  : decode hazard queries
//   issue_ready, hazard_a/b,
//   busy_mask                     : scoreboard status (combinational)
//   wb_en, wb_addr, wb_data       : register file write port
//   wb_elem                       : vector element index of this write
module etapa_wb
    import wb_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int IMM_W  = WB_IMM_W,
    parameter int REG_AW = WB_REG_AW,
    parameter int CNT_W  = WB_CNT_W,
    parameter int ELEM_W = WB_ELEM_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_in,
    input  logic [DATA_W-1:0]      data_in,
    input  logic [IMM_W-1:0]       inmediate_in,
    input  logic [REG_AW-1:0]      dir_dest_in,
    input  logic [1:0]             sel_wb,
    input  logic                   last_in,
    input  logic [DATA_W-1:0]      mem_q,
    input  logic                   issue_valid,
    input  logic [REG_AW-1:0]      issue_dest,
    input  logic [REG_AW-1:0]      chk_a,
    input  logic [REG_AW-1:0]      chk_b,
    output logic                   issue_ready,
    output logic                   hazard_a,
    output logic                   hazard_b,
    output logic                   wb_en,
    output logic [REG_AW-1:0]      wb_addr,
    output logic [DATA_W-1:0]      wb_data,
    output logic [ELEM_W-1:0]      wb_elem,
    output logic [(1<<REG_AW)-1:0] busy_mask
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [IMM_W-1:0]  r_imm;
    logic [REG_AW-1:0] r_dest;
    wb_sel_t           r_sel;
    logic              r_last;

    logic              commit;
    logic [DATA_W-1:0] wb_data_d;
    logic [ELEM_W-1:0] elem_cnt;

    // Capture register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_imm   <= '0;
            r_dest  <= '0;
            r_sel   <= WB_SEL_DATA;
            r_last  <= 1'b0;
        end else begin
            r_valid <= valid_in;
            if (valid_in) begin
                r_data <= data_in;
                r_imm  <= inmediate_in;
                r_dest <= dir_dest_in;
                r_sel  <= wb_sel_t'(sel_wb);
                r_last <= last_in;
            end
        end
    end

    assign commit = r_valid && (r_sel != WB_SEL_NONE);

    // Source mux; mem_q is the RAM word for the captured instruction.
    always_comb begin
        wb_data_d = r_data;
        case (r_sel)
            WB_SEL_MEM: wb_data_d = mem_q;
            WB_SEL_IMM: wb_data_d = DATA_W'(r_imm);
            default:    wb_data_d = r_data;
        endcase
    end

    // Register file write port and element counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en    <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            wb_elem  <= '0;
            elem_cnt <= '0;
        end else begin
            wb_en <= commit;
            if (commit) begin
                wb_addr  <= r_dest;
                wb_data  <= wb_data_d;
                wb_elem  <= elem_cnt;
                // The last element carries its own index; the next run restarts at 0.
                elem_cnt <= r_last ? '0 : elem_cnt + ELEM_W'(1);
            end
        end
    end

    wb_scoreboard #(
        .REG_AW (REG_AW),
        .CNT_W  (CNT_W)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_dest  (issue_dest),
        .commit      (commit),
        .commit_dest (r_dest),
        .chk_a       (chk_a),
        .chk_b       (chk_b),
        .issue_ready (issue_ready),
        .hazard_a    (hazard_a),
        .hazard_b    (hazard_b),
        .busy_mask   (busy_mask)
    );

endmodule

// File: tb/tb_etapa_wb.sv
module tb_etapa_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [31:0] data_in;
    logic [7:0]  inmediate_in;
    logic [2:0]  dir_dest_in;
    logic [1:0]  sel_wb;
    logic        last_in;
    logic [31:0] mem_q;
    logic        issue_valid;
    logic [2:0]  issue_dest;
    logic [2:0]  chk_a, chk_b;
    logic        issue_ready, hazard_a, hazard_b, wb_en;
    logic [2:0]  wb_addr;
    logic [31:0] wb_data;
    logic [7:0]  wb_elem;
    logic [7:0]  busy_mask;

    always #5 clk = ~clk;

    etapa_wb dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
        .inmediate_in(inmediate_in), .dir_dest_in(dir_dest_in), .sel_wb(sel_wb),
        .last_in(last_in), .mem_q(mem_q), .issue_valid(issue_valid),
        .issue_dest(issue_dest), .chk_a(chk_a), .chk_b(chk_b),
        .issue_ready(issue_ready), .hazard_a(hazard_a), .hazard_b(hazard_b),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_elem(wb_elem),
        .busy_mask(busy_mask)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: the instruction waiting to commit, pending counts
    // per register, element index and the expected write-port contents.
    logic        m_v;
    logic [31:0] m_d;
    logic [7:0]  m_im;
    int          m_ds, m_sl;
    logic        m_lst;
    int          cnt [8];
    int          elem;
    logic        e_en;
    int          e_addr, e_elem;
    logic [31:0] e_data;

    task automatic model_reset();
        m_v = 0; m_d = 0; m_im = 0; m_ds = 0; m_sl = 0; m_lst = 0;
        foreach (cnt[i]) cnt[i] = 0;
        elem = 0; e_en = 0; e_addr = 0; e_data = 0; e_elem = 0;
    endtask

    function automatic logic [7:0] model_busy();
        logic [7:0] b = 0;
        for (int i = 0; i < 8; i++) b[i] = (cnt[i] > 0);
        return b;
    endfunction

    // One clock cycle: drive at negedge, check combinational scoreboard view,
    // advance the model at posedge, check the write port at the next negedge.
    task automatic step(input logic v, input logic [31:0] d, input logic [7:0] im,
                        input int ds, input int sl, input logic lst, input logic [31:0] mq,
                        input logic iv, input int idst, input int ca, input int cb);
        bit commit, acc;
        valid_in = v; data_in = d; inmediate_in = im; dir_dest_in = 3'(ds);
        sel_wb = 2'(sl); last_in = lst; mem_q = mq;
        issue_valid = iv; issue_dest = 3'(idst); chk_a = 3'(ca); chk_b = 3'(cb);
        #1;
        chk("issue_ready", 32'(issue_ready), 32'(cnt[idst] != 3));
        chk("hazard_a",    32'(hazard_a),    32'(cnt[ca] != 0));
        chk("hazard_b",    32'(hazard_b),    32'(cnt[cb] != 0));
        chk("busy_mask",   32'(busy_mask),   32'(model_busy()));
        @(posedge clk);
        commit = m_v && (m_sl != 3);
        acc    = iv && (cnt[idst] != 3);
        e_en   = commit;
        if (commit) begin
            e_addr = m_ds;
            e_data = (m_sl == 0) ? m_d : (m_sl == 1) ? mq : {24'b0, m_im};
            e_elem = elem;
            elem   = m_lst ? 0 : (elem + 1) % 256;
        end
        if (!(acc && commit && idst == m_ds)) begin
            if (acc) cnt[idst]++;
            if (commit && cnt[m_ds] > 0) cnt[m_ds]--;
        end
        m_v = v;
        if (v) begin
            m_d = d; m_im = im; m_ds = ds; m_sl = sl; m_lst = lst;
        end
        @(negedge clk);
        chk("wb_en",   32'(wb_en),   32'(e_en));
        chk("wb_addr", 32'(wb_addr), 32'(e_addr));
        chk("wb_data", wb_data,      e_data);
        chk("wb_elem", 32'(wb_elem), 32'(e_elem));
    endtask

    task automatic idle(input int ca);
        step(0, 0, 0, 0, 0, 0, 32'hBAD0BAD0, 0, 0, ca, 0);
    endtask

    initial begin
        rst = 1'b1;
        valid_in = 0; data_in = 0; inmediate_in = 0; dir_dest_in = 0; sel_wb = 0;
        last_in = 0; mem_q = 0; issue_valid = 0; issue_dest = 0; chk_a = 0; chk_b = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_wb_en",   32'(wb_en),       0);
        chk("rst_wb_addr", 32'(wb_addr),     0);
        chk("rst_wb_data", wb_data,          0);
        chk("rst_wb_elem", 32'(wb_elem),     0);
        chk("rst_busy",    32'(busy_mask),   0);
        chk("rst_ready",   32'(issue_ready), 1);
        rst = 1'b0;

        // Source select and RAM alignment
        step(1, 32'hDEADBEEF, 8'h11, 3, 0, 0, 32'hFFFF0000, 0, 0, 0, 0);
        step(1, 32'h0,        8'hA5, 1, 2, 0, 32'h0,        0, 0, 0, 0);
        step(1, 32'hCAFE0000, 8'h00, 7, 3, 0, 32'h0,        0, 0, 0, 0);
        step(1, 32'h0,        8'h00, 4, 1, 0, 32'hBAADF00D, 0, 0, 0, 0);
        step(0, 32'h0,        8'h00, 0, 0, 0, 32'h12345678, 0, 0, 0, 0);
        idle(0); idle(0);

        // Vector run to dest 5, last on the 4th, then one more write
        for (int i = 0; i < 5; i++)
            step(1, 32'(100 + i), 8'h0, 5, 0, (i == 3), 32'h0, 0, 0, 0, 0);
        idle(0); idle(0);

        // Saturation on register 2, then drain it
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 2, 2, 0);
        for (int i = 0; i < 3; i++) step(1, 32'(i), 0, 2, 0, 0, 0, 0, 0, 2, 2);
        idle(2); idle(2); idle(2);

        // Issue 6 while a write to 6 commits with counter already at 1
        step(0, 0, 0, 0, 0, 0, 0, 1, 6, 6, 6);
        step(1, 32'h66, 0, 6, 0, 0, 0, 0, 0, 6, 6);
        step(0, 0, 0, 0, 0, 0, 0, 1, 6, 6, 6);
        idle(6); idle(6);
        // Issue 1 while a write to 4 commits
        step(0, 0, 0, 0, 0, 0, 0, 1, 4, 4, 1);
        step(1, 32'h44, 0, 4, 0, 0, 0, 0, 0, 4, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 4, 1);
        idle(4); idle(1);
        // drain register 1 and 6
        step(1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 6);
        step(1, 0, 0, 6, 0, 0, 0, 0, 0, 1, 6);
        idle(1); idle(6);

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) < 7, $urandom, 8'($urandom), $urandom_range(0, 7),
                 $urandom_range(0, 3), $urandom_range(0, 5) == 0, $urandom,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 7));

        // Async reset mid-stream with a write captured and counters busy
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(1, 32'h1111, 0, 0, 0, 0, 0, 1, 3, 0, 0);
        step(1, 32'h2222, 0, 3, 0, 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_wb_en", 32'(wb_en),     0);
        chk("arst_busy",  32'(busy_mask), 0);
        chk("arst_elem",  32'(wb_elem),   0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle(0); idle(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/etapa_wb.md
Name: etapa_wb

Overview:
- Write-back stage of the vector processor, directly downstream of the MEM stage.
- Captures MEM-stage outputs and aligns them with the one-cycle-late RAM read data.
- Selects the write-back source and drives the 8-entry register file write port.
- Keeps a per-register pending-write scoreboard that decode queries for RAW hazards, plus a vector element index for the current destination.

Parameters:
- DATA_W, 32, data/RAM word width
- IMM_W, 8, immediate width (zero-extended to DATA_W)
- REG_AW, 3, register address width (2^REG_AW registers)
- CNT_W, 2, width of each scoreboard pending counter
- ELEM_W, 8, vector element index width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- valid_in  in  1  MEM stage presents a valid instruction this cycle
- data_in  in  DATA_W  MEM stage data output (ALU result or operand)
- inmediate_in  in  IMM_W  MEM stage immediate output
- dir_dest_in  in  REG_AW  destination register
- sel_wb  in  2  source select: 00 data, 01 RAM, 10 immediate, 11 no write
- last_in  in  1  final element of the vector operation
- mem_q  in  DATA_W  RAM read data, valid one cycle after valid_in
- issue_valid  in  1  decode issues an instruction that will write a register
- issue_dest  in  REG_AW  destination of the issued instruction
- chk_a, chk_b  in  REG_AW  decode source registers to check
- issue_ready  out  1  issue_dest counter not saturated
- hazard_a, hazard_b  out  1  source register has a pending write
- wb_en  out  1  register file write enable
- wb_addr  out  REG_AW  register file write address
- wb_data  out  DATA_W  register file write data
- wb_elem  out  ELEM_W  element index of the current write
- busy_mask  out  2^REG_AW  bit i set when register i counter is nonzero

Behaviour:
- Reset: all registered outputs are 0, all counters 0, and the capture register is invalid. Async assert clears immediately, mid-operation included, and drops any in-flight write.
- Capture (edge E1): when valid_in=1, latch data_in, inmediate_in, dir_dest_in, sel_wb, last_in and set r_valid. When valid_in=0, r_valid=0.
- Commit (edge E2, next edge): when r_valid and sel!=11:
  - wb_en=1 and wb_addr=r_dest.
  - wb_data = r_data, mem_q sampled at E2, or zero-extended r_imm, according to sel.
  - wb_elem = current element counter.
- Commit with sel=11: wb_en=0 and no scoreboard change.
- Otherwise wb_en=0. wb_addr and wb_data hold their last values.
- Latency: valid_in in cycle N gives wb_en high in cycle N+2. Throughput is one instruction per cycle with no backpressure.
- Element counter:
  - Increments on each committed write; 255 wraps to 0.
  - Returns to 0 after a commit with r_last=1, so that write carries the final index and the next write carries 0.
- Scoreboard: one CNT_W counter per register.
  - Accepted issue (issue_valid && issue_ready): +1 on issue_dest.
  - Commit write: −1 on r_dest.
  - Both on the same register in the same cycle: counter unchanged.
  - Both on different registers: both updates apply.
  - issue_ready = (counter[issue_dest] != max), combinational. An issue while not ready is ignored.
  - A commit to a register whose counter is 0 leaves it at 0 (no underflow).
- Hazard outputs are combinational from the current counters: hazard_x = (counter[chk_x] != 0). There is no bypass of a write committing in the same cycle; decode re-checks the next cycle.
- busy_mask is combinational from the counters.

Decomposition:
- Package wb_pkg:
  - sel_wb encodings: WB_SEL_DATA, WB_SEL_MEM, WB_SEL_IMM, WB_SEL_NONE.
  - Width constants.
- Sub-module wb_scoreboard: the counter array, issue/commit arithmetic, issue_ready, hazard and busy_mask logic.
- Capture register, source mux and element counter stay in etapa_wb.

Test Plan:
- Reset: assert rst mid-stream with a write pending → same cycle wb_en=0, busy_mask=0, wb_elem=0. The captured write never appears.
- Source select:
  - Cycle 0: valid_in, sel=00, data_in=0xDEADBEEF, dest=3 → cycle 2: wb_en=1, wb_addr=3, wb_data=0xDEADBEEF.
  - sel=10, imm=0xA5 → wb_data=0x000000A5.
  - sel=11 → wb_en stays 0.
- RAM alignment: sel=01 with mem_q=0x12345678 driven only in cycle 1 (garbage in cycle 0) → wb_data=0x12345678.
- Vector run: 4 back-to-back writes to dest 5, last_in on the 4th, then one more write → wb_elem = 0,1,2,3 then 0. Writes commit on consecutive cycles.
- Scoreboard saturation:
  - Issue dest 2 three times → busy_mask[2]=1, issue_ready=0 on the 4th attempt, which is not counted.
  - Commit three writes to 2 → counter 0, hazard_a (chk_a=2) deasserts.
- Simultaneous events:
  - Issue dest 6 in the same cycle a write to 6 commits with counter=1 → counter stays 1, hazard stays 1.
  - Issue 1 while committing 4 → counter[1]=1, counter[4]=0.
